// File: rtl/lif_tdm_scheduler.sv
// Time-multiplexed LIF scheduler: once per timestep, sweeps N_NEUR virtual neurons through one
// shared membrane-update datapath, storing each neuron's potential and collecting its spike.
module lif_tdm_scheduler #(
    parameter int N_NEUR  = 4,
    parameter int V_W     = 8,
    parameter int TIMEOUT = 15
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      tick,
    input  logic [N_NEUR-1:0]         stim_in,
    input  logic                      clr_flags,
    output logic                      dp_valid,
    input  logic                      dp_ready,
    output logic [$clog2(N_NEUR)-1:0] dp_idx,
    output logic [V_W-1:0]            dp_v_in,
    output logic                      dp_stim,
    input  logic                      dp_done,
    input  logic [V_W-1:0]            dp_v_out,
    input  logic                      dp_spike,
    output logic [N_NEUR-1:0]         spikes,
    output logic                      done,
    output logic                      busy,
    output logic                      overrun,
    output logic                      timeout_err,
    output logic [7:0]                step_cnt
);
    localparam int            IW        = $clog2(N_NEUR);
    localparam logic [IW-1:0] LAST_IDX  = IW'(N_NEUR - 1);
    localparam logic [7:0]    WAIT_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [7:0]        wait_q, wait_d;
    logic [V_W-1:0]    vmem_q [N_NEUR];
    logic [N_NEUR-1:0] stim_q;
    logic [N_NEUR-1:0] spk_acc_q;
    logic [N_NEUR-1:0] spikes_q;
    logic [7:0]        step_q;
    logic              overrun_q;
    logic              timeout_q;
    logic              accept;
    logic              result_we;
    logic              timeout_hit;
    logic              advance;
    logic              tick_drop;

    // Any tick outside IDLE, including the DONE cycle, is dropped.
    assign tick_drop = tick && (state_q != S_IDLE);

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        wait_d      = wait_q;
        accept      = 1'b0;
        result_we   = 1'b0;
        timeout_hit = 1'b0;
        advance     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (tick) begin
                    accept  = 1'b1;
                    idx_d   = '0;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (dp_ready) begin
                    wait_d  = '0;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (dp_done) begin
                    result_we = 1'b1;
                    advance   = 1'b1;
                end else if (wait_q == WAIT_LAST) begin
                    timeout_hit = 1'b1;
                    advance     = 1'b1;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        if (advance) begin
            if (idx_q == LAST_IDX) begin
                state_d = S_DONE;
            end else begin
                idx_d   = idx_q + 1'b1;
                state_d = S_ISSUE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            wait_q  <= wait_d;
        end
    end

    // A timed-out neuron keeps its potential but reports no spike.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_NEUR; i++) begin
                vmem_q[i] <= '0;
            end
            stim_q    <= '0;
            spk_acc_q <= '0;
            spikes_q  <= '0;
            step_q    <= '0;
            overrun_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            if (accept) begin
                stim_q <= stim_in;
            end
            if (result_we) begin
                vmem_q[idx_q]    <= dp_v_out;
                spk_acc_q[idx_q] <= dp_spike;
            end else if (timeout_hit) begin
                spk_acc_q[idx_q] <= 1'b0;
            end
            if (state_q == S_DONE) begin
                spikes_q <= spk_acc_q;
                step_q   <= step_q + 8'd1;
            end
            overrun_q <= (overrun_q & ~clr_flags) | tick_drop;
            timeout_q <= (timeout_q & ~clr_flags) | timeout_hit;
        end
    end

    assign dp_valid    = (state_q == S_ISSUE);
    assign dp_idx      = idx_q;
    assign dp_v_in     = vmem_q[idx_q];
    assign dp_stim     = stim_q[idx_q];
    assign done        = (state_q == S_DONE);
    assign busy        = (state_q != S_IDLE);
    assign spikes      = spikes_q;
    assign step_cnt    = step_q;
    assign overrun     = overrun_q;
    assign timeout_err = timeout_q;

endmodule
